// File: rtl/lfsr_checker.sv
// Self-synchronising PRBS checker for the 16-bit LFSR stream (fb = s0^s2^s3^s5).
// locked/error/error_count update 1 clk after the causing valid bit; no backpressure, in_valid=0 simply holds all state.
module lfsr_checker #(
  parameter int LOCK_MATCHES = 32,
  parameter int LOSS_ERRORS  = 8,
  parameter int LOSS_WINDOW  = 64,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clr_count,
  output logic             locked,
  output logic             error,
  output logic [CNT_W-1:0] error_count
);

  localparam int MW = $clog2(LOCK_MATCHES + 1);
  localparam int WW = $clog2(LOSS_WINDOW + 1);
  localparam int EW = $clog2(LOSS_ERRORS + 1);

  typedef enum logic [1:0] {FILL, SEARCH, LOCKED} state_t;

  state_t        state;
  logic [15:0]   h;
  logic [3:0]    fill_cnt;
  logic [MW-1:0] match_cnt;
  logic [WW-1:0] win_bits;
  logic [EW-1:0] win_err;

  logic          pred;
  logic          mism;
  logic          count_err;
  logic [EW-1:0] win_err_nxt;

  assign pred        = h[0] ^ h[2] ^ h[3] ^ h[5];
  assign mism        = in_bit != pred;
  assign count_err   = in_valid && (state == LOCKED) && mism;
  assign win_err_nxt = win_err + EW'(mism);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FILL;
      h           <= '0;
      fill_cnt    <= '0;
      match_cnt   <= '0;
      win_bits    <= '0;
      win_err     <= '0;
      locked      <= 1'b0;
      error       <= 1'b0;
      error_count <= '0;
    end else begin
      error <= 1'b0;

      // A clear coincident with a counted error leaves exactly that one error.
      if (clr_count)
        error_count <= CNT_W'(count_err);
      else if (count_err && (error_count != '1))
        error_count <= error_count + 1'b1;

      if (in_valid) begin
        case (state)
          FILL: begin
            h <= {in_bit, h[15:1]};
            if (fill_cnt == 4'd15) begin
              state    <= SEARCH;
              fill_cnt <= '0;
            end else begin
              fill_cnt <= fill_cnt + 1'b1;
            end
          end

          SEARCH: begin
            h <= {in_bit, h[15:1]};
            // The all-zero history is a fixed point of the predictor, never a valid lock.
            if (!mism && (h != '0)) begin
              if (match_cnt == MW'(LOCK_MATCHES - 1)) begin
                state     <= LOCKED;
                locked    <= 1'b1;
                match_cnt <= '0;
                win_bits  <= '0;
                win_err   <= '0;
              end else begin
                match_cnt <= match_cnt + 1'b1;
              end
            end else begin
              match_cnt <= '0;
            end
          end

          LOCKED: begin
            // Free-run on our own prediction so a received error is not multiplied.
            h     <= {pred, h[15:1]};
            error <= mism;
            if (win_err_nxt == EW'(LOSS_ERRORS)) begin
              state     <= FILL;
              locked    <= 1'b0;
              fill_cnt  <= '0;
              match_cnt <= '0;
              win_bits  <= '0;
              win_err   <= '0;
            end else if (win_bits == WW'(LOSS_WINDOW - 1)) begin
              win_bits <= '0;
              win_err  <= '0;
            end else begin
              win_bits <= win_bits + 1'b1;
              win_err  <= win_err_nxt;
            end
          end

          default: state <= FILL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: lock acquisition, error reporting, loss/relock, gaps, reset/clear/saturation.
// error_count width is narrowed to 4 bits so saturation is reachable without losing lock.
module tb_lfsr_checker;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_bit;
  logic          clr_count;
  logic          locked;
  logic          error;
  logic [CW-1:0] error_count;

  int nvec = 0;
  int nerr = 0;

  logic [15:0] gen;

  lfsr_checker #(.CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .clr_count   (clr_count),
    .locked      (locked),
    .error       (error),
    .error_count (error_count)
  );

  always #5 clk = ~clk;

  task automatic next_bit(output logic b);
    b   = gen[0];
    gen = {gen[0] ^ gen[2] ^ gen[3] ^ gen[5], gen[15:1]};
  endtask

  // Drive one cycle and return 1 time unit after the edge so outputs are settled.
  task automatic tick(input logic v, input logic b, input logic c);
    in_valid  = v;
    in_bit    = b;
    clr_count = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    gen = 16'hACE1;
  endtask

  task automatic lock_up();
    logic b;
    for (int k = 0; k < 48; k++) begin
      next_bit(b);
      tick(1'b1, b, 1'b0);
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b1; in_bit = 1'b1; clr_count = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    nvec++; if (locked !== 1'b0) begin nerr++; $display("FAIL reset_locked: got %b expected 0", locked); end
    nvec++; if (error !== 1'b0) begin nerr++; $display("FAIL reset_error: got %b expected 0", error); end
    nvec++; if (error_count !== 4'd0) begin nerr++; $display("FAIL reset_count: got %0d expected 0", error_count); end
  endtask

  task automatic test_lock_clean();
    logic b;
    int   pulses = 0;
    int   drops  = 0;
    do_reset();
    for (int k = 1; k <= 1000; k++) begin
      next_bit(b);
      tick(1'b1, b, 1'b0);
      if (error) pulses++;
      if (k == 47) begin
        nvec++; if (locked !== 1'b0) begin nerr++; $display("FAIL lock_early: got %b expected 0 after bit 47", locked); end
      end
      if (k == 48) begin
        nvec++; if (locked !== 1'b1) begin nerr++; $display("FAIL lock_rise: got %b expected 1 after bit 48", locked); end
      end
      if (k > 48 && !locked) drops++;
    end
    nvec++; if (pulses != 0) begin nerr++; $display("FAIL clean_pulses: got %0d expected 0", pulses); end
    nvec++; if (drops != 0) begin nerr++; $display("FAIL clean_drops: got %0d expected 0", drops); end
    nvec++; if (error_count !== 4'd0) begin nerr++; $display("FAIL clean_count: got %0d expected 0", error_count); end
  endtask

  task automatic test_single_error();
    logic b;
    int   pulses = 0;
    int   drops  = 0;
    do_reset();
    lock_up();
    for (int k = 0; k < 10; k++) begin next_bit(b); tick(1'b1, b, 1'b0); end
    next_bit(b);
    tick(1'b1, ~b, 1'b0);
    nvec++; if (error !== 1'b1) begin nerr++; $display("FAIL single_pulse: got %b expected 1", error); end
    nvec++; if (error_count !== 4'd1) begin nerr++; $display("FAIL single_count: got %0d expected 1", error_count); end
    nvec++; if (locked !== 1'b1) begin nerr++; $display("FAIL single_locked: got %b expected 1", locked); end
    next_bit(b);
    tick(1'b1, b, 1'b0);
    nvec++; if (error !== 1'b0) begin nerr++; $display("FAIL single_width: got %b expected 0", error); end
    for (int k = 0; k < 200; k++) begin
      next_bit(b);
      tick(1'b1, b, 1'b0);
      if (error) pulses++;
      if (!locked) drops++;
    end
    nvec++; if (pulses != 0) begin nerr++; $display("FAIL single_after: got %0d pulses expected 0", pulses); end
    nvec++; if (drops != 0) begin nerr++; $display("FAIL single_drops: got %0d expected 0", drops); end
    nvec++; if (error_count !== 4'd1) begin nerr++; $display("FAIL single_final: got %0d expected 1", error_count); end
  endtask

  task automatic test_loss_relock();
    logic b;
    do_reset();
    lock_up();
    for (int i = 0; i < 8; i++) begin
      next_bit(b);
      tick(1'b1, ~b, 1'b0);
      if (i == 6) begin
        nvec++; if (locked !== 1'b1) begin nerr++; $display("FAIL loss_7th: got %b expected 1", locked); end
      end
    end
    nvec++; if (locked !== 1'b0) begin nerr++; $display("FAIL loss_8th: got %b expected 0", locked); end
    nvec++; if (error !== 1'b1) begin nerr++; $display("FAIL loss_pulse: got %b expected 1", error); end
    for (int k = 1; k <= 48; k++) begin
      next_bit(b);
      tick(1'b1, b, 1'b0);
      if (k == 47) begin
        nvec++; if (locked !== 1'b0) begin nerr++; $display("FAIL relock_early: got %b expected 0", locked); end
      end
    end
    nvec++; if (locked !== 1'b1) begin nerr++; $display("FAIL relock: got %b expected 1", locked); end
    nvec++; if (error_count !== 4'd8) begin nerr++; $display("FAIL loss_count: got %0d expected 8", error_count); end
  endtask

  task automatic test_stuck();
    int seen   = 0;
    int pulses = 0;
    do_reset();
    for (int k = 0; k < 500; k++) begin
      tick(1'b1, 1'b0, 1'b0);
      if (locked) seen++;
      if (error) pulses++;
    end
    nvec++; if (seen != 0) begin nerr++; $display("FAIL zeros_lock: got %0d locked cycles expected 0", seen); end
    seen = 0;
    for (int k = 0; k < 500; k++) begin
      tick(1'b1, 1'b1, 1'b0);
      if (locked) seen++;
      if (error) pulses++;
    end
    nvec++; if (seen != 0) begin nerr++; $display("FAIL ones_lock: got %0d locked cycles expected 0", seen); end
    nvec++; if (pulses != 0) begin nerr++; $display("FAIL stuck_pulses: got %0d expected 0", pulses); end
    nvec++; if (error_count !== 4'd0) begin nerr++; $display("FAIL stuck_count: got %0d expected 0", error_count); end
  endtask

  task automatic test_gaps();
    logic b;
    int   pulses = 0;
    int   early  = 0;
    do_reset();
    for (int k = 1; k <= 248; k++) begin
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        tick(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        if (error) pulses++;
        if (k <= 48 && locked) early++;
      end
      next_bit(b);
      tick(1'b1, b, 1'b0);
      if (error) pulses++;
      if (k == 47) begin
        nvec++; if (locked !== 1'b0) begin nerr++; $display("FAIL gap_early: got %b expected 0", locked); end
      end
      if (k == 48) begin
        nvec++; if (locked !== 1'b1) begin nerr++; $display("FAIL gap_lock: got %b expected 1", locked); end
      end
    end
    nvec++; if (early != 0) begin nerr++; $display("FAIL gap_idle_lock: got %0d expected 0", early); end
    nvec++; if (pulses != 0) begin nerr++; $display("FAIL gap_pulses: got %0d expected 0", pulses); end
    nvec++; if (locked !== 1'b1) begin nerr++; $display("FAIL gap_hold: got %b expected 1", locked); end
  endtask

  task automatic test_reset_clear_sat();
    logic b;
    do_reset();
    lock_up();
    for (int i = 0; i < 5; i++) begin next_bit(b); tick(1'b1, ~b, 1'b0); end
    nvec++; if (error_count !== 4'd5) begin nerr++; $display("FAIL pre_rst_count: got %0d expected 5", error_count); end
    next_bit(b);
    rst = 1'b1;
    tick(1'b1, ~b, 1'b0);
    rst = 1'b0;
    nvec++; if (locked !== 1'b0) begin nerr++; $display("FAIL rst_locked: got %b expected 0", locked); end
    nvec++; if (error_count !== 4'd0) begin nerr++; $display("FAIL rst_count: got %0d expected 0", error_count); end
    nvec++; if (error !== 1'b0) begin nerr++; $display("FAIL rst_error: got %b expected 0", error); end

    do_reset();
    lock_up();
    next_bit(b); tick(1'b1, ~b, 1'b0);
    next_bit(b); tick(1'b1, ~b, 1'b1);
    nvec++; if (error_count !== 4'd1) begin nerr++; $display("FAIL clr_coincident: got %0d expected 1", error_count); end
    nvec++; if (error !== 1'b1) begin nerr++; $display("FAIL clr_pulse: got %b expected 1", error); end
    tick(1'b0, 1'b0, 1'b1);
    nvec++; if (error_count !== 4'd0) begin nerr++; $display("FAIL clr_idle: got %0d expected 0", error_count); end

    do_reset();
    lock_up();
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 64; i++) begin
        next_bit(b);
        tick(1'b1, b ^ (i < 7), 1'b0);
      end
      if (w == 1) begin
        nvec++; if (error_count !== 4'd14) begin nerr++; $display("FAIL sat_mid: got %0d expected 14", error_count); end
      end
    end
    nvec++; if (error_count !== 4'hF) begin nerr++; $display("FAIL sat_final: got %0d expected 15", error_count); end
    nvec++; if (locked !== 1'b1) begin nerr++; $display("FAIL sat_locked: got %b expected 1", locked); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; clr_count = 1'b0;
    gen = 16'hACE1;
    test_reset();
    test_lock_clean();
    test_single_error();
    test_loss_relock();
    test_stuck();
    test_gaps();
    test_reset_clear_sat();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
